// File: rtl/cap_sense_driver.sv
// cap_sense_driver: excitation side of an RC capacitive pad.
//
// Each measurement runs through these phases:
// - Discharge the pad with sensor_out low.
// - Drive sensor_out high and count clock cycles until the synchronised
//   receive pin rises, or until CHARGE_TIMEOUT cycles pass.
// - Discharge the pad again.
// The result appears on final_count_out and timeout, and done pulses for one
// cycle when they update.
//
// Build option: define CAP_SENSE_AUTO_REPEAT_EN for continuous measurement.
// With it, RELEASE loops straight back to PRECHARGE_DIS, so one start keeps
// the block measuring until resetn.
//
// Ports:
//   clock            system clock, rising edge
//   resetn           asynchronous active-low reset
//   start            request one measurement (sampled only in IDLE)
//   sensor_in        receive pin, asynchronous to clock
//   sensor_out       send pin drive (1 = charge, 0 = discharge)
//   busy             high in every state except IDLE
//   done             one-cycle pulse in the first RELEASE cycle
//   timeout          1 = last measurement saw no rise before the timeout
//   count_out        live charge counter
//   final_count_out  latched result of the last measurement
module cap_sense_driver #(
    parameter int unsigned COUNT_W          = 32,
    parameter int unsigned DISCHARGE_CYCLES = 5000,
    parameter int unsigned CHARGE_TIMEOUT   = 100000,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               sensor_in,
    output logic               sensor_out,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [COUNT_W-1:0] count_out,
    output logic [COUNT_W-1:0] final_count_out
);

    // The timer only ever reaches DISCHARGE_CYCLES-1.
    localparam int unsigned TIMER_W = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST    = TIMER_W'(DISCHARGE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_LAST    = COUNT_W'(CHARGE_TIMEOUT - 1);
    localparam logic [COUNT_W-1:0] COUNT_TIMEOUT = COUNT_W'(CHARGE_TIMEOUT);

    localparam logic [1:0] ST_IDLE          = 2'd0;
    localparam logic [1:0] ST_PRECHARGE_DIS = 2'd1;
    localparam logic [1:0] ST_CHARGE        = 2'd2;
    localparam logic [1:0] ST_RELEASE       = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_in;
    logic [1:0]             state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic [COUNT_W-1:0]     final_q, final_d;
    logic                   timeout_q, timeout_d;
    logic                   done_q, done_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_in};
        end
    end

    assign s_in = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        count_d   = count_q;
        final_d   = final_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PRECHARGE_DIS;
                    timer_d = '0;
                end
            end
            ST_PRECHARGE_DIS: begin
                // A pad that still reads high has not discharged yet.
                // Park at the last timer value until it drops.
                if (timer_q >= TIMER_LAST) begin
                    if (!s_in) begin
                        state_d = ST_CHARGE;
                        count_d = '0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_CHARGE: begin
                count_d = count_q + 1'b1;
                // A rise seen on the last allowed cycle still counts as a hit.
                if (s_in) begin
                    final_d   = count_q;
                    timeout_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_RELEASE;
                    timer_d   = '0;
                end else if (count_q == COUNT_LAST) begin
                    final_d   = COUNT_TIMEOUT;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_RELEASE;
                    timer_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (timer_q == TIMER_LAST) begin
`ifdef CAP_SENSE_AUTO_REPEAT_EN
                    state_d = ST_PRECHARGE_DIS;
                    timer_d = '0;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            count_q   <= '0;
            final_q   <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            final_q   <= final_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    // Decoded straight from the state so that reset drops the drive at once.
    assign sensor_out      = (state_q == ST_CHARGE);
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign timeout         = timeout_q;
    assign count_out       = count_q;
    assign final_count_out = final_q;

endmodule

// File: tb/tb_cap_sense_driver.sv
// Bench for cap_sense_driver with DISCHARGE_CYCLES=4, CHARGE_TIMEOUT=20, SYNC_STAGES=2.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled at the same point.
module tb_cap_sense_driver;

    localparam int W    = 16;
    localparam int DIS  = 4;
    localparam int TMO  = 20;
    localparam int SYNC = 2;

    logic         clock;
    logic         resetn;
    logic         start;
    logic         sensor_in;
    logic         sensor_out;
    logic         busy;
    logic         done;
    logic         timeout;
    logic [W-1:0] count_out;
    logic [W-1:0] final_count_out;

    int total = 0;
    int bad   = 0;

    cap_sense_driver #(
        .COUNT_W         (W),
        .DISCHARGE_CYCLES(DIS),
        .CHARGE_TIMEOUT  (TMO),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .start          (start),
        .sensor_in      (sensor_in),
        .sensor_out     (sensor_out),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .count_out      (count_out),
        .final_count_out(final_count_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One start pulse, then observe a whole measurement.
    // sensor_in is raised d cycles after sensor_out rises; d < 0 means never.
    // With spam set, start is toggled randomly while busy, and forced high on the done cycle.
    task automatic measure(input int d, input bit spam, output int hi, output int dn,
                           output int rel, output logic [W-1:0] fin, output logic to,
                           output bit ok, output bit done_pos_ok);
        int  k;
        bit  rose;
        bit  seen_done;
        bit  prev_out;
        hi = 0; dn = 0; rel = 0; ok = 0; done_pos_ok = 1;
        k = 0; rose = 0; seen_done = 0; prev_out = 0;
        sensor_in = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (sensor_out) begin
                if (!rose) begin
                    rose = 1;
                    k = 0;
                end
                hi++;
            end
            if (spam) start = 1'($urandom_range(0, 1));
            if (done) begin
                dn++;
                seen_done = 1;
                if (sensor_out || !prev_out) done_pos_ok = 0;
                if (spam) start = 1'b1;
            end
            if (seen_done && busy && !sensor_out) rel++;
            if (rose && d >= 0 && k == d) sensor_in = 1'b1;
            if (!busy) begin
                ok = 1;
                break;
            end
            if (rose) k++;
            prev_out = sensor_out;
            step();
        end
        start = 1'b0;
        fin = final_count_out;
        to  = timeout;
        sensor_in = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; sensor_in = 1'b0;
        #3;
        total++;
        if ({sensor_out, busy, done, timeout, count_out, final_count_out} !== '0) begin
            bad++;
            $display("FAIL reset_initial: got out=%b busy=%b done=%b to=%b cnt=%0d fin=%0d, want all 0",
                     sensor_out, busy, done, timeout, count_out, final_count_out);
        end
        step(); step();
        #2 resetn = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_normal();
        int hi, dn, rel, d;
        logic [W-1:0] fin;
        logic to;
        bit ok, dpo;
        int exp_fin, exp_hi;
        bit exp_to;
        measure(7, 0, hi, dn, rel, fin, to, ok, dpo);
        total++;
        if (!ok || fin !== 9 || to !== 1'b0) begin
            bad++;
            $display("FAIL normal_result: ok=%0d fin=%0d to=%b, want ok=1 fin=9 to=0", ok, fin, to);
        end
        total++;
        if (dn != 1 || !dpo) begin
            bad++;
            $display("FAIL normal_done: pulses=%0d placement_ok=%0d, want 1/1", dn, dpo);
        end
        total++;
        if (hi != 10 || rel != DIS) begin
            bad++;
            $display("FAIL normal_phases: high=%0d release=%0d, want 10/%0d", hi, rel, DIS);
        end
        // Random rise delays, some beyond the timeout.
        for (int i = 0; i < 8; i++) begin
            d = int'($urandom_range(0, 22));
            if (d + SYNC < TMO) begin
                exp_fin = d + SYNC; exp_to = 0; exp_hi = d + SYNC + 1;
            end else begin
                exp_fin = TMO; exp_to = 1; exp_hi = TMO;
            end
            measure(d, 0, hi, dn, rel, fin, to, ok, dpo);
            total++;
            if (!ok || fin !== W'(exp_fin) || to !== exp_to || hi != exp_hi || dn != 1) begin
                bad++;
                $display("FAIL normal_rand d=%0d: fin=%0d to=%b high=%0d done=%0d, want %0d %b %0d 1",
                         d, fin, to, hi, dn, exp_fin, exp_to, exp_hi);
            end
        end
    endtask

    task automatic test_timeout();
        int hi, dn, rel;
        logic [W-1:0] fin;
        logic to;
        bit ok, dpo;
        measure(-1, 0, hi, dn, rel, fin, to, ok, dpo);
        total++;
        if (!ok || fin !== W'(TMO) || to !== 1'b1) begin
            bad++;
            $display("FAIL timeout_result: ok=%0d fin=%0d to=%b, want 1 %0d 1", ok, fin, to, TMO);
        end
        total++;
        if (hi != TMO || dn != 1 || !dpo || rel != DIS) begin
            bad++;
            $display("FAIL timeout_phases: high=%0d done=%0d rel=%0d, want %0d 1 %0d",
                     hi, dn, rel, TMO, DIS);
        end
    endtask

    task automatic test_reset_mid_charge();
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!sensor_out && n < 20) begin
            step();
            n++;
        end
        step(); step(); step();
        #2 resetn = 1'b0;
        #1;
        total++;
        if (sensor_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_drop: sensor_out=%b want 0", sensor_out);
        end
        total++;
        if ({busy, done, timeout, count_out, final_count_out} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b to=%b cnt=%0d fin=%0d, want all 0",
                     busy, done, timeout, count_out, final_count_out);
        end
        step();
        #2 resetn = 1'b1;
        step(); step();
        total++;
        if (busy !== 1'b0 || sensor_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_stay_idle: busy=%b out=%b want 0 0", busy, sensor_out);
        end
    endtask

    task automatic test_stuck_high();
        bit   bad_seen;
        int   n;
        sensor_in = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        bad_seen = 0;
        repeat (15) begin
            if (sensor_out !== 1'b0 || done !== 1'b0 || busy !== 1'b1) bad_seen = 1;
            step();
        end
        total++;
        if (bad_seen) begin
            bad++;
            $display("FAIL stuck_wait: got a charge/done/idle while pad high, want none");
        end
        sensor_in = 1'b0;
        n = 0;
        while (!sensor_out && n < 10) begin
            step();
            n++;
        end
        total++;
        if (n != SYNC + 1) begin
            bad++;
            $display("FAIL stuck_release: charge after %0d cycles, want %0d", n, SYNC + 1);
        end
        sensor_in = 1'b1;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        sensor_in = 1'b0;
        total++;
        if (busy || final_count_out !== W'(SYNC) || timeout !== 1'b0) begin
            bad++;
            $display("FAIL stuck_result: busy=%b fin=%0d to=%b, want 0 %0d 0",
                     busy, final_count_out, timeout, SYNC);
        end
    endtask

    task automatic test_busy_start();
        int hi, dn, rel, d;
        logic [W-1:0] fin;
        logic to;
        bit ok, dpo, restarted;
        d = int'($urandom_range(3, 10));
        measure(d, 1, hi, dn, rel, fin, to, ok, dpo);
        total++;
        if (!ok || dn != 1 || fin !== W'(d + SYNC)) begin
            bad++;
            $display("FAIL busy_start: ok=%0d done=%0d fin=%0d, want 1 1 %0d", ok, dn, fin, d + SYNC);
        end
        restarted = 0;
        repeat (6) begin
            step();
            if (busy) restarted = 1;
        end
        total++;
        if (restarted) begin
            bad++;
            $display("FAIL busy_no_queue: busy=1 after measurement, want 0");
        end
    endtask

`ifdef CAP_SENSE_AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        logic [2:0] hist;
        int   last, nd;
        bit   dropped, res_bad, gap_bad;
        hist = '0; last = -1; nd = 0; dropped = 0; res_bad = 0; gap_bad = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (!busy) dropped = 1;
            if (done) begin
                if (final_count_out !== W'(3 + SYNC) || timeout !== 1'b0) res_bad = 1;
                if (last >= 0 && cyc - last != 2 * DIS + 3 + SYNC + 1) gap_bad = 1;
                last = cyc;
                nd++;
            end
            sensor_in = hist[2];
            hist = {hist[1:0], sensor_out};
            step();
        end
        total++;
        if (dropped || nd < 4) begin
            bad++;
            $display("FAIL auto_busy: dropped=%0d dones=%0d, want 0 >=4", dropped, nd);
        end
        total++;
        if (res_bad || gap_bad) begin
            bad++;
            $display("FAIL auto_result: res_bad=%0d gap_bad=%0d, want 0 0", res_bad, gap_bad);
        end
        sensor_in = 1'b0;
        #2 resetn = 1'b0;
        step();
        #2 resetn = 1'b1;
        step(); step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL auto_stop: busy=%b after reset, want 0", busy);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CAP_SENSE_AUTO_REPEAT_EN
        test_auto_repeat();
`else
        test_normal();
        test_timeout();
        test_reset_mid_charge();
        test_stuck_high();
        test_busy_start();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
